// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle for logic_unit_pipe.
// master = producer/consumer side, slave = the pipeline itself.
interface logic_unit_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_y
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_y
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// Eight-way bitwise logic unit feeding a STAGES-deep valid/ready pipeline, with a saturating delivered-result counter.
// Latency: STAGES cycles from accept to out_y when unstalled; one beat per cycle throughput.
// Backpressure: stages fill under stall and bubbles collapse; in_ready drops only when all stages hold beats and out_ready=0.
module logic_unit_pipe #(
    parameter int WIDTH   = 8,
    parameter int STAGES  = 2,
    parameter int COUNT_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    logic_unit_pipe_if.slave   bus,
    input  logic               cnt_clr,
    output logic [COUNT_W-1:0] res_count
);

    logic [STAGES-1:0]  v_q;
    logic [STAGES-1:0]  v_d;
    logic [WIDTH-1:0]   d_q [STAGES];
    logic [WIDTH-1:0]   d_d [STAGES];
    logic [STAGES-1:0]  rdy;
    logic               hole;
    logic [WIDTH-1:0]   op_y;
    logic               fire;
    logic [COUNT_W-1:0] cnt_q;
    logic [COUNT_W-1:0] cnt_d;

    always_comb begin
        op_y = bus.in_a;
        case (bus.in_op)
            3'b000:  op_y = ~bus.in_a;
            3'b001:  op_y = bus.in_a & bus.in_b;
            3'b010:  op_y = bus.in_a | bus.in_b;
            3'b011:  op_y = bus.in_a ^ bus.in_b;
            3'b100:  op_y = ~(bus.in_a & bus.in_b);
            3'b101:  op_y = ~(bus.in_a | bus.in_b);
            3'b110:  op_y = ~(bus.in_a ^ bus.in_b);
            default: op_y = bus.in_a;
        endcase
    end

    // A stage can advance if the consumer is ready or any stage downstream of it is empty.
    always_comb begin
        rdy  = '0;
        hole = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            hole   = hole || !v_q[k];
            rdy[k] = hole;
        end
    end

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (rdy[0]) begin
            v_d[0] = bus.in_valid;
            // Operand bus is don't-care when idle, so stage 1 data only moves on a real beat.
            if (bus.in_valid) begin
                d_d[0] = op_y;
            end
        end
        for (int k = 1; k < STAGES; k++) begin
            if (rdy[k]) begin
                v_d[k] = v_q[k-1];
                d_d[k] = d_q[k-1];
            end
        end
    end

    assign fire = v_q[STAGES-1] && bus.out_ready;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (fire && (cnt_q != {COUNT_W{1'b1}})) begin
            cnt_d = cnt_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            v_q   <= '0;
            cnt_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                d_q[k] <= '0;
            end
        end else begin
            v_q   <= v_d;
            d_q   <= d_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = v_q[STAGES-1];
    assign bus.out_y     = d_q[STAGES-1];
    assign res_count     = cnt_q;

endmodule
